// File: rtl/snn_run_sequencer_pkg.sv
// Shared types and defaults for the SNN run sequencer (package snn_pkg).
package snn_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned TS_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE
  } run_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_run_sequencer_if.sv
// Run-control handshake between a host and the SNN run sequencer.
interface snn_run_sequencer_if #(
  parameter int unsigned TS_BITS = 8
);
  logic               start;
  logic               abort;
  logic [31:0]        sim_time;
  logic [TS_BITS-1:0] pattern_len;
  logic               busy;
  logic               done;
  logic [31:0]        timestep;

  modport master (
    output start, abort, sim_time, pattern_len,
    input  busy, done, timestep
  );

  modport slave (
    input  start, abort, sim_time, pattern_len,
    output busy, done, timestep
  );
endinterface

// File: rtl/snn_spike_counter_bank.sv
// Bank of saturating per-output spike counters with synchronous clear.
module snn_spike_counter_bank #(
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [NUM_OUTPUTS-1:0]       spikes,
  output logic [NUM_OUTPUTS*CNT_W-1:0] counts
);

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable && spikes[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign counts[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: rtl/snn_run_sequencer.sv
// Sequences one SNN inference run: clear, N timesteps of advance, done.
// Optional winner-take-all readout when SNN_RUN_WINNER_EN is defined.
module snn_run_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned TS_BITS     = TS_BITS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  localparam int unsigned WIN_W      = idx_width(NUM_OUTPUTS)
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  snn_run_sequencer_if.slave           ctrl,
  input  logic [NUM_INPUTS-1:0]        src_sel,
  input  logic [NUM_INPUTS-1:0]        bernoulli_spikes,
  input  logic [NUM_INPUTS-1:0]        pattern_spikes,
  input  logic [NUM_OUTPUTS-1:0]       net_spikes_out,
  output logic                         net_rst,
  output logic                         net_en,
  output logic [TS_BITS-1:0]           pattern_addr,
  output logic [NUM_INPUTS-1:0]        spike_in,
`ifdef SNN_RUN_WINNER_EN
  output logic [WIN_W-1:0]             winner,
  output logic                         winner_valid,
`endif
  output logic [NUM_OUTPUTS*CNT_W-1:0] spike_counts
);

  run_state_t         state_q, state_d;
  logic [31:0]        timestep_q;
  logic [TS_BITS-1:0] addr_q;
  logic               last_step;
  logic               addr_wrap;
  logic               advance;

  // sim_time and pattern_len are compared live so mid-run edits take effect at once
  assign last_step = ({1'b0, timestep_q} + 33'd1) >= {1'b0, ctrl.sim_time};
  assign addr_wrap = (ctrl.pattern_len != '0) &&
                     (({1'b0, addr_q} + 1'b1) >= {1'b0, ctrl.pattern_len});
  assign advance   = (state_q == ST_RUN) && !ctrl.abort && !last_step;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (ctrl.start && !ctrl.abort) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (ctrl.abort)                state_d = ST_IDLE;
        else if (ctrl.sim_time == '0)  state_d = ST_DONE;
        else                           state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl.abort)      state_d = ST_IDLE;
        else if (last_step)  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      timestep_q <= '0;
      addr_q     <= '0;
    end else if (state_q == ST_CLEAR) begin
      timestep_q <= '0;
      addr_q     <= '0;
    end else if (advance) begin
      timestep_q <= timestep_q + 32'd1;
      addr_q     <= addr_wrap ? '0 : addr_q + 1'b1;
    end
  end

  snn_spike_counter_bank #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .CNT_W       (CNT_W)
  ) u_counters (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .clear  (state_q == ST_CLEAR),
    .enable ((state_q == ST_RUN) && !ctrl.abort),
    .spikes (net_spikes_out),
    .counts (spike_counts)
  );

  assign net_rst       = !S_AXI_ARESETN || (state_q == ST_CLEAR);
  assign net_en        = (state_q == ST_RUN);
  assign ctrl.busy     = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign ctrl.done     = (state_q == ST_DONE);
  assign ctrl.timestep = timestep_q;
  assign pattern_addr  = addr_q;
  assign spike_in      = (src_sel & bernoulli_spikes) | (~src_sel & pattern_spikes);

`ifdef SNN_RUN_WINNER_EN
  logic [WIN_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  // strict greater-than keeps the lowest index on ties
  always_comb begin
    best_idx = '0;
    best_cnt = spike_counts[0 +: CNT_W];
    for (int unsigned i = 1; i < NUM_OUTPUTS; i++) begin
      if (spike_counts[i*CNT_W +: CNT_W] > best_cnt) begin
        best_cnt = spike_counts[i*CNT_W +: CNT_W];
        best_idx = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if ((state_q == ST_DONE) && !winner_valid) begin
      winner       <= best_idx;
      winner_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Self-checking bench for snn_run_sequencer: directed scenarios plus random runs
// checked against a timestep-level reference model.
module tb_snn_run_sequencer;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int TB = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] src_sel = '0, bern = '0, pat = '0, spike_in;
  logic [NO-1:0] net_spikes = '0;
  logic net_rst, net_en;
  logic [TB-1:0] pattern_addr;
  logic [NO*CW-1:0] counts;
`ifdef SNN_RUN_WINNER_EN
  logic [1:0] winner;
  logic       winner_valid;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt[NO];

  snn_run_sequencer_if #(.TS_BITS(TB)) bus ();

  always #5 clk = ~clk;

  snn_run_sequencer #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .TS_BITS(TB), .CNT_W(CW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .ctrl(bus),
    .src_sel(src_sel), .bernoulli_spikes(bern), .pattern_spikes(pat),
    .net_spikes_out(net_spikes), .net_rst(net_rst), .net_en(net_en),
    .pattern_addr(pattern_addr), .spike_in(spike_in),
`ifdef SNN_RUN_WINNER_EN
    .winner(winner), .winner_valid(winner_valid),
`endif
    .spike_counts(counts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NO*CW-1:0] pack_counts();
    logic [NO*CW-1:0] p = '0;
    for (int o = 0; o < NO; o++) p[o*CW +: CW] = CW'(exp_cnt[o]);
    return p;
  endfunction

  function automatic logic [NI-1:0] mux_ref(input logic [NI-1:0] s, b, p);
    logic [NI-1:0] r;
    for (int i = 0; i < NI; i++) r[i] = s[i] ? b[i] : p[i];
    return r;
  endfunction

  // mode 0: random spikes, 1: only output 0 fires, 2: outputs 1,2 always, output 0 first 5 steps
  task automatic run(input int st, input int pl, input int abort_at, input int shrink_at,
                     input int mode);
    int cur_st, eff_len, k;
    logic [NO-1:0] ns;
    bit last;
    cur_st = st;
    eff_len = (pl == 0) ? (1 << TB) : pl;
    bus.sim_time = st;
    bus.pattern_len = TB'(pl);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("clear_net_rst", net_rst, 1);
    check("clear_busy", bus.busy, 1);
    check("clear_net_en", net_en, 0);
    for (int o = 0; o < NO; o++) exp_cnt[o] = 0;
    tick();
    k = 0;
    while (cur_st > 0) begin
      check("run_net_en", net_en, 1);
      check("run_busy", bus.busy, 1);
      check("run_timestep", bus.timestep, k);
      check("run_addr", pattern_addr, k % eff_len);
      if (k == shrink_at) begin
        cur_st = k;
        bus.sim_time = k;
      end
      if (k == abort_at) begin
        ns = '0;
        bus.abort = 1'b1;
      end else if (mode == 1) ns = 3'b001;
      else if (mode == 2) ns = {2'b11, (k < 5)};
      else ns = NO'($urandom);
      net_spikes = ns;
      for (int o = 0; o < NO; o++)
        if (ns[o] && exp_cnt[o] < CMAX) exp_cnt[o]++;
      src_sel = NI'($urandom);
      bern = NI'($urandom);
      pat = NI'($urandom);
      #1;
      check("run_spike_in", spike_in, mux_ref(src_sel, bern, pat));
      last = (k + 1 >= cur_st);
      tick();
      net_spikes = '0;
      if (k == abort_at) begin
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_net_en", net_en, 0);
        check("abort_timestep", bus.timestep, k);
        check("abort_counts", counts, pack_counts());
        return;
      end
      if (last) break;
      k++;
    end
    check("done_flag", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("done_net_en", net_en, 0);
    check("done_timestep", bus.timestep, k);
    check("done_counts", counts, pack_counts());
`ifdef SNN_RUN_WINNER_EN
    begin
      int best = 0;
      for (int o = 1; o < NO; o++) if (exp_cnt[o] > exp_cnt[best]) best = o;
      tick();
      check("winner_valid", winner_valid, 1);
      check("winner_idx", winner, best);
    end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sim_time = '0;
    bus.pattern_len = '0;
    #3;
    check("rst_net_rst", net_rst, 1);
    check("rst_net_en", net_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_timestep", bus.timestep, 0);
    check("rst_addr", pattern_addr, 0);
    check("rst_counts", counts, 0);
`ifdef SNN_RUN_WINNER_EN
    check("rst_winner_valid", winner_valid, 0);
`endif
    #9 rst_n = 1'b1;
    tick();
    check("idle_net_rst", net_rst, 0);

    src_sel = 4'b0101; bern = 4'hF; pat = 4'h0;
    #1 check("mux_directed", spike_in, 4'b0101);

    run(10, 4, -1, -1, 0);
    run(0, 4, -1, -1, 0);
    run(20, 3, -1, -1, 1);
    check("saturated_count0", counts[CW-1:0], CMAX);
    run(9, 0, -1, -1, 2);
    run(10, 5, -1, 4, 0);
    run(10, 4, 3, -1, 0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);
    check("start_abort_net_rst", net_rst, 0);
    check("start_abort_timestep", bus.timestep, 3);

    for (int r = 0; r < 12; r++)
      run($urandom_range(0, 30), $urandom_range(0, 7), -1, -1, 0);

    bus.sim_time = 20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    net_spikes = '1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_net_rst", net_rst, 1);
    check("midrst_net_en", net_en, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_timestep", bus.timestep, 0);
    check("midrst_counts", counts, 0);
    net_spikes = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("postrst_busy", bus.busy, 0);
    check("postrst_done", bus.done, 0);
    check("postrst_net_rst", net_rst, 0);
    check("postrst_net_en", net_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_run_sequencer.md
SNN_RUN_SEQUENCER -- requirements
Module: snn_run_sequencer

Interface
REQ-001 Parameter NUM_INPUTS, default 4: input spike channel count.
REQ-002 Parameter NUM_OUTPUTS, default 1: output neuron count.
REQ-003 Parameter TS_BITS, default 8: pattern address width.
REQ-004 Parameter CNT_W, default 32: per-output spike counter width.
REQ-005 Port S_AXI_ACLK, in, 1: the only clock; all state changes on its rising edge.
REQ-006 Port S_AXI_ARESETN, in, 1: reset, asynchronous assertion, active-low.
REQ-007 Ports start/abort, in, 1/1: single-cycle run request / run cancel.
REQ-008 Ports sim_time, in, 32, and pattern_len, in, TS_BITS: run length in timesteps / pattern wrap length.
REQ-009 Port src_sel, in, NUM_INPUTS: per-channel source select; 1=bernoulli, 0=pattern.
REQ-010 Ports bernoulli_spikes/pattern_spikes, in, NUM_INPUTS each: candidate input spikes.
REQ-011 Port net_spikes_out, in, NUM_OUTPUTS: network output spikes.
REQ-012 Ports net_rst/net_en, out, 1/1: network clear / network advance.
REQ-013 Ports pattern_addr, out, TS_BITS, and spike_in, out, NUM_INPUTS: pattern memory address / muxed network input.
REQ-014 Ports busy/done, out, 1/1; timestep, out, 32; spike_counts, out, NUM_OUTPUTS*CNT_W (channel i at bits [i*CNT_W +: CNT_W]).

Function
REQ-015 FSM states IDLE, CLEAR, RUN, DONE; registered, one-hot or binary at implementer's choice.
REQ-016 IDLE/DONE + start -> CLEAR; start in CLEAR/RUN ignored.
REQ-017 CLEAR lasts exactly one cycle: net_rst=1, timestep, pattern_addr, all counters cleared, done cleared; next state RUN, or DONE if sim_time==0.
REQ-018 RUN: net_en=1, busy=1; timestep increments by 1 each cycle; RUN -> DONE on the cycle timestep==sim_time-1 (exactly sim_time RUN cycles).
REQ-019 pattern_addr increments each RUN cycle, wraps to 0 after pattern_len-1; pattern_len==0 means full 2^TS_BITS range.
REQ-020 spike_in[i] = src_sel[i] ? bernoulli_spikes[i] : pattern_spikes[i], combinational, all states.
REQ-021 Counter i increments when state==RUN and net_spikes_out[i]==1; saturates at 2^CNT_W-1, no wrap.
REQ-022 DONE: done=1, busy=0, net_en=0; counters and timestep held until next CLEAR.
REQ-023 abort in CLEAR/RUN -> IDLE next cycle, done stays 0, counters/timestep held; abort with start same cycle: abort wins.
REQ-024 sim_time/pattern_len changes during RUN take effect immediately (compared live); sim_time lowered below timestep+1 -> DONE next cycle.

Reset
REQ-025 S_AXI_ARESETN low: state IDLE, net_rst=1 (combinationally while reset asserted), net_en=0, busy=0, done=0, timestep=0, pattern_addr=0, counters=0, winner outputs 0.
REQ-026 Reset mid-run discards run; no output pulses on release.

Configuration
REQ-027 Macro SNN_RUN_WINNER_EN defined: adds outputs winner ($clog2(NUM_OUTPUTS) bits, min 1) and winner_valid; one cycle after DONE entry, winner = lowest index with maximum count, winner_valid=1 until next CLEAR/reset.
REQ-028 Macro undefined: no winner ports, no comparator logic.

Structure
REQ-029 Shared package snn_pkg holds the state enum type and CNT_W/TS_BITS defaults.
REQ-030 One sub-module snn_spike_counter_bank (NUM_OUTPUTS saturating counters, clear/enable inputs).

Verification
REQ-031 sim_time=10, pattern_len=4, start -> CLEAR 1 cycle, net_en high 10 cycles, pattern_addr 0,1,2,3,0,1,2,3,0,1, done=1, timestep=9.
REQ-032 sim_time=0, start -> CLEAR then DONE, net_en never high, counters 0.
REQ-033 CNT_W=4, net_spikes_out[0]=1 for sim_time=20 -> count[0]=15 (saturated).
REQ-034 abort at RUN cycle 3 of sim_time=10 -> IDLE, done=0, timestep=3 held; start+abort same cycle from IDLE -> stays IDLE.
REQ-035 src_sel=4'b0101, bernoulli=4'hF, pattern=4'h0 -> spike_in=4'b0101.
REQ-036 With SNN_RUN_WINNER_EN, NUM_OUTPUTS=3, counts {5,9,9} -> winner=1, winner_valid=1 one cycle after done.
